// File: rtl/mole_scheduler_if.sv
// Handshake-free signal bundle between the game sequencer and its PRNG, buttons and display drivers.
// The master drives timebase, controls, PRNG state and buttons; the slave drives mole/score status.
interface mole_scheduler_if #(
  parameter int NUM_HOLES = 4
);
  logic                 tick;
  logic                 start;
  logic                 stop;
  logic [7:0]           random;
  logic [NUM_HOLES-1:0] buttons;
  logic [NUM_HOLES-1:0] mole;
  logic                 hit;
  logic                 miss;
  logic [7:0]           score;
  logic [7:0]           misses;
  logic                 busy;
  logic                 game_over;

  modport master (
    output tick, start, stop, random, buttons,
    input  mole, hit, miss, score, misses, busy, game_over
  );

  modport slave (
    input  tick, start, stop, random, buttons,
    output mole, hit, miss, score, misses, busy, game_over
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: random gap, random hole (never the same twice), hit/timeout scoring.
// All outputs registered; gap and up times count tick enables, and stop aborts from any state.
module mole_scheduler #(
  parameter int NUM_HOLES  = 4,
  parameter int MIN_GAP    = 4,
  parameter int UP_TIME    = 16,
  parameter int MAX_MISSES = 5
) (
  input  logic             clk,
  input  logic             rst,
  mole_scheduler_if.slave  bus
);
  localparam int HB = $clog2(NUM_HOLES);
  localparam logic [NUM_HOLES-1:0] ONE_HOT0 = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [HB-1:0]        last_hole_q, last_hole_d;
  logic [NUM_HOLES-1:0] btn_q, btn_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [7:0]           score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic                 busy_q, busy_d;
  logic                 game_over_q, game_over_d;

  logic [NUM_HOLES-1:0] btn_rise;
  logic [7:0]           gap_load;
  logic [HB-1:0]        hole;
  logic [7:0]           misses_inc;

  assign btn_rise   = bus.buttons & ~btn_q;
  assign gap_load   = 8'(MIN_GAP) + {4'd0, bus.random[7:4]};
  assign misses_inc = misses_q + 8'd1;

  // Avoid lighting the same hole twice in a row by stepping to the neighbour.
  always_comb begin
    hole = bus.random[HB-1:0];
    if (hole == last_hole_q) hole = hole + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_hole_d = last_hole_q;
    btn_d       = bus.buttons;
    mole_d      = mole_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    score_d     = score_q;
    misses_d    = misses_q;

    if (bus.stop) begin
      state_d = S_IDLE;
      mole_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            score_d  = '0;
            misses_d = '0;
            cnt_d    = gap_load;
            state_d  = S_GAP;
          end
        end
        S_GAP: begin
          if (bus.tick) begin
            if (cnt_q == 8'd0) begin
              state_d     = S_UP;
              mole_d      = ONE_HOT0 << hole;
              last_hole_d = hole;
              cnt_d       = 8'(UP_TIME);
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        S_UP: begin
          // A hit outranks a timeout landing on the same cycle.
          if ((btn_rise & mole_q) != '0) begin
            hit_d   = 1'b1;
            if (score_q != 8'hff) score_d = score_q + 8'd1;
            mole_d  = '0;
            cnt_d   = gap_load;
            state_d = S_GAP;
          end else if (bus.tick && cnt_q == 8'd0) begin
            miss_d   = 1'b1;
            misses_d = misses_inc;
            mole_d   = '0;
            if (misses_inc == 8'(MAX_MISSES)) begin
              state_d = S_OVER;
            end else begin
              cnt_d   = gap_load;
              state_d = S_GAP;
            end
          end else if (bus.tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d      = (state_d == S_GAP) || (state_d == S_UP);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_hole_q <= '0;
      btn_q       <= '0;
      mole_q      <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      misses_q    <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_hole_q <= last_hole_d;
      btn_q       <= btn_d;
      mole_q      <= mole_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.mole      = mole_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// Directed scenario for mole_scheduler; expected events are queued by the stimulus and
// checked by an independent monitor whenever the DUT pulses hit/miss or raises a mole.
module tb_mole_scheduler;
  typedef struct {
    string      name;
    logic [3:0] mole;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [7:0] misses;
    logic       busy;
    logic       game_over;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   t0  = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [3:0] mole_prev = 4'b0;

  mole_scheduler_if #(.NUM_HOLES(4)) bus ();

  mole_scheduler #(
    .NUM_HOLES(4), .MIN_GAP(2), .UP_TIME(3), .MAX_MISSES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic at(input int t);
    while (cyc < t0 + t) @(negedge clk);
  endtask

  task automatic expect_ev(input string nm, input logic [3:0] m, input logic h, input logic ms,
                           input logic [7:0] s, input logic [7:0] mi, input logic b,
                           input logic g, input int t);
    ev_t e;
    e.name = nm; e.mole = m; e.hit = h; e.miss = ms; e.score = s; e.misses = mi;
    e.busy = b; e.game_over = g; e.cyc = t0 + t;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  // Monitor: every DUT event must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if (bus.hit || bus.miss || (bus.mole != 4'b0 && mole_prev == 4'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: mole=%b hit=%b miss=%b score=%0d misses=%0d cyc=%0d",
                 bus.mole, bus.hit, bus.miss, bus.score, bus.misses, cyc - t0);
      end else begin
        e = exp_q.pop_front();
        if (bus.mole !== e.mole || bus.hit !== e.hit || bus.miss !== e.miss ||
            bus.score !== e.score || bus.misses !== e.misses || bus.busy !== e.busy ||
            bus.game_over !== e.game_over || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got mole=%b hit=%b miss=%b score=%0d misses=%0d busy=%b go=%b t=%0d; expected mole=%b hit=%b miss=%b score=%0d misses=%0d busy=%b go=%b t=%0d",
                   e.name, bus.mole, bus.hit, bus.miss, bus.score, bus.misses, bus.busy,
                   bus.game_over, cyc - t0, e.mole, e.hit, e.miss, e.score, e.misses,
                   e.busy, e.game_over, e.cyc - t0);
        end
      end
    end
    mole_prev = bus.mole;
  end

  initial begin
    bus.tick = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    bus.random = 8'h00; bus.buttons = 4'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_mole",   32'(bus.mole), 32'h0);
    chk("reset_flags",  {28'h0, bus.hit, bus.miss, bus.busy, bus.game_over}, 32'h0);
    chk("reset_counts", {16'h0, bus.score, bus.misses}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    t0 = cyc;

    // Gap of 2+5 ticks, then hole 1.
    bus.start = 1'b1; bus.random = 8'h50;
    expect_ev("first_up",  4'b0010, 0, 0, 8'd0, 8'd0, 1, 0, 9);
    at(1);
    bus.start = 1'b0; bus.random = 8'h01;
    chk("gap_busy", {31'h0, bus.busy}, 32'h1);
    chk("gap_mole", 32'(bus.mole), 32'h0);
    at(9);
    bus.buttons = 4'b0100;                 // wrong hole
    at(10);
    bus.buttons = 4'b0110;                 // right hole rises, hole 2 stays held
    expect_ev("hit1",      4'b0000, 1, 0, 8'd1, 8'd0, 1, 0, 11);
    expect_ev("collide_up",4'b0100, 0, 0, 8'd1, 8'd0, 1, 0, 14);
    expect_ev("miss1",     4'b0000, 0, 1, 8'd1, 8'd1, 1, 0, 18);
    expect_ev("up3",       4'b0010, 0, 0, 8'd1, 8'd1, 1, 0, 21);
    at(15);
    bus.buttons = 4'b0000;
    at(24);
    bus.buttons = 4'b0010;                 // hit on the final timeout tick
    expect_ev("hit_at_timeout", 4'b0000, 1, 0, 8'd2, 8'd1, 1, 0, 25);
    expect_ev("up4",       4'b0100, 0, 0, 8'd2, 8'd1, 1, 0, 28);
    expect_ev("miss2",     4'b0000, 0, 1, 8'd2, 8'd2, 1, 0, 32);
    expect_ev("up5",       4'b0010, 0, 0, 8'd2, 8'd2, 1, 0, 35);
    expect_ev("miss3_over",4'b0000, 0, 1, 8'd2, 8'd3, 0, 1, 39);
    at(25);
    bus.buttons = 4'b0000;
    at(40);
    chk("over_flags", {30'h0, bus.busy, bus.game_over}, 32'h1);
    bus.buttons = 4'b0001;                 // ignored in OVER
    at(42);
    bus.start = 1'b1; bus.random = 8'h00;
    at(43);
    chk("restart_counts", {16'h0, bus.score, bus.misses}, 32'h0);
    chk("restart_flags",  {30'h0, bus.busy, bus.game_over}, 32'h2);
    bus.start = 1'b0; bus.buttons = 4'b0000;
    expect_ev("up6",       4'b0001, 0, 0, 8'd0, 8'd0, 1, 0, 46);
    at(46);
    bus.buttons = 4'b0001;
    expect_ev("hit2",      4'b0000, 1, 0, 8'd1, 8'd0, 1, 0, 47);
    expect_ev("up7",       4'b0010, 0, 0, 8'd1, 8'd0, 1, 0, 50);
    at(47);
    bus.buttons = 4'b0000;
    at(51);
    bus.stop = 1'b1;
    at(52);
    chk("stop_mole",  32'(bus.mole), 32'h0);
    chk("stop_busy",  {31'h0, bus.busy}, 32'h0);
    chk("stop_score", 32'(bus.score), 32'h1);
    bus.start = 1'b1;                      // start with stop held
    at(53);
    chk("start_stop_idle",  {31'h0, bus.busy}, 32'h0);
    chk("start_stop_score", 32'(bus.score), 32'h1);
    bus.start = 1'b0; bus.stop = 1'b0;
    at(54);
    bus.start = 1'b1;
    expect_ev("up8",       4'b0001, 0, 0, 8'd0, 8'd0, 1, 0, 58);
    at(55);
    bus.start = 1'b0;
    at(58);
    bus.buttons = 4'b0001;
    expect_ev("hit3",      4'b0000, 1, 0, 8'd1, 8'd0, 1, 0, 59);
    expect_ev("up9",       4'b0010, 0, 0, 8'd1, 8'd0, 1, 0, 62);
    at(59);
    bus.buttons = 4'b0000;
    at(63);
    rst = 1'b1;                            // mid-UP asynchronous reset
    #1;
    chk("rst_mid_mole",   32'(bus.mole), 32'h0);
    chk("rst_mid_counts", {16'h0, bus.score, bus.misses}, 32'h0);
    chk("rst_mid_flags",  {30'h0, bus.busy, bus.game_over}, 32'h0);
    at(65);
    rst = 1'b0;
    at(67);
    chk("events_pending", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
